// File: rtl/mult32x32_seq_ctrl.sv
// mult32x32_seq_ctrl: FIFO-buffered request sequencer driving the iterative 32x32 multiplier.
// Define MULT_SEQ_CNT_EN to add the op_count port and completed-result counter.
module mult32x32_seq_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_a,
  input  logic [31:0]                in_b,
  output logic                       mult_start,
  output logic [31:0]                mult_a,
  output logic [31:0]                mult_b,
  input  logic                       mult_busy,
  input  logic [63:0]                mult_product,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [63:0]                out_product,
  output logic [$clog2(DEPTH):0]     fifo_level
`ifdef MULT_SEQ_CNT_EN
  ,
  output logic [CNT_W-1:0]           op_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t          state_q;
  logic [31:0]     mem_a_q [DEPTH];
  logic [31:0]     mem_b_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     level_q, level_d;
  logic            push, pop, capture;
  assign in_ready   = level_q != FULL;
  assign push       = in_valid && in_ready;
  assign pop        = state_q == IDLE && level_q != '0;
  assign capture    = state_q == WAIT_DONE && !mult_busy && (!out_valid || out_ready);
  assign level_d    = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign mult_start = state_q == ISSUE;
  assign fifo_level = level_q;
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_q] <= in_a;
      mem_b_q[wr_q] <= in_b;
    end
  end
  // Product is only captured once busy has dropped; the multiplier holds it until the next start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_q        <= '0;
      rd_q        <= '0;
      level_q     <= '0;
      mult_a      <= '0;
      mult_b      <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      level_q   <= level_d;
      out_valid <= capture || (out_valid && !out_ready);
      if (capture) out_product <= mult_product;
      unique case (state_q)
        IDLE: if (pop) begin
          mult_a  <= mem_a_q[rd_q];
          mult_b  <= mem_b_q[rd_q];
          state_q <= ISSUE;
        end
        ISSUE:     state_q <= WAIT_BUSY;
        WAIT_BUSY: if (mult_busy) state_q <= WAIT_DONE;
        WAIT_DONE: if (capture) state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end
`ifdef MULT_SEQ_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) op_count <= '0;
    else if (capture) op_count <= op_count + 1'b1;
  end
`endif
endmodule
